adc_uart_sequencer: RTL and testbench
=====================================

Name: adc_uart_sequencer

Overview:
Controller that periodically samples the serial ADC and streams each 12-bit result to the UART transmitter as ASCII text. Sits between the ADC receiver (request / in-process / data-valid handshake) and the UART transmitter (data-valid / good-to-reset / send-complete handshake). It replaces ad-hoc counter-compare sequencing at top level with a single FSM.

Parameters:
SAMPLE_PERIOD, 50000000, clock cycles between sample ticks (1 s at 50 MHz); minimum 16
ADC_TIMEOUT, 4096, max cycles from request to ADC data-valid before abort
ADC_CFG, 6'b100000, config bits driven to the ADC receiver

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_enable  in  1  sampling enable
i_clr_status  in  1  clears sticky flags
o_adc_request  out  1  conversion request to ADC receiver
o_adc_cfg  out  6  constant ADC_CFG
i_adc_conv_in_process  in  1  ADC receiver busy
i_adc_dv  in  1  ADC result valid, 1-cycle pulse
i_adc_data  in  12  ADC result
o_tx_byte  out  8  byte to UART transmitter
o_tx_dv  out  1  UART data valid
i_tx_good_to_reset_dv  in  1  UART accepted byte
i_tx_send_complete  in  1  UART stop bit finished
o_busy  out  1  FSM not in IDLE
o_overrun  out  1  sticky: tick arrived while busy
o_adc_err  out  1  sticky: ADC timeout

Behaviour:
- Reset (async, i_rst_n low): state IDLE; all outputs 0 except o_adc_cfg = ADC_CFG; tick counter, char index, captured sample cleared.
- Tick counter: held at 0 while i_enable=0; otherwise counts 0..SAMPLE_PERIOD-1 and wraps; tick = counter at SAMPLE_PERIOD-1. First tick comes SAMPLE_PERIOD cycles after i_enable rises.
- FSM states: IDLE, REQ, WAIT_DATA, LOAD, WAIT_ACK, WAIT_DONE.
- IDLE: on tick and i_enable -> REQ, with o_adc_request=1 on the next cycle.
- REQ: o_adc_request held high until i_adc_conv_in_process=1 seen, then dropped -> WAIT_DATA. i_adc_dv seen while in REQ is accepted as in WAIT_DATA.
- WAIT_DATA: timeout counter starts at the request. On i_adc_dv, capture i_adc_data, char index=0, go to LOAD. If ADC_TIMEOUT cycles elapse first, set o_adc_err and go to IDLE; nothing is transmitted.
- LOAD: drive o_tx_byte for the current index; o_tx_dv=1 -> WAIT_ACK.
- WAIT_ACK: on i_tx_good_to_reset_dv, o_tx_dv=0 -> WAIT_DONE.
- WAIT_DONE: on i_tx_send_complete, increment index. If index was last, go to IDLE; else go to LOAD.
- Handshake edge case: if good_to_reset and send_complete arrive in the same cycle in WAIT_ACK, both are honoured (dv dropped and index advanced).
- Frame, binary format: 14 bytes. Bits 11..0 MSB first as 8'h30 + bit, then 8'h0D, then 8'h0A.
  - Example: 12'hAB3 -> "101010110011\r\n".
- Overrun: a tick while not IDLE sets o_overrun; that tick is dropped, with no queueing.
- i_enable falling mid-frame: the current frame completes, then FSM stays IDLE.
- i_clr_status clears o_overrun and o_adc_err. If a set event occurs in the same cycle, the set wins.
- o_busy = (state != IDLE), registered.

Optional Feature:
ADC_UART_HEX_FORMAT_EN
- Defined: frame is 5 bytes: 3 uppercase hex digits MSB nibble first ('0'-'9' = 8'h30+n, 'A'-'F' = 8'h37+n), then CR, LF.
  - Example: 12'hAB3 -> "AB3\r\n".
- Undefined: binary 14-byte frame as above.

Decomposition:
- Shared package adc_uart_pkg:
  - FSM state enum
  - ASCII constants: CHAR_ZERO 8'h30, CHAR_CR 8'h0D, CHAR_LF 8'h0A, CHAR_HEX_ALPHA_OFS 8'h37
  - frame length constants (14 / 5)
- One sub-module, ascii_char_mux: combinational; maps captured sample plus char index to o_tx_byte; contains the format ifdef.

Test Plan:
1. SAMPLE_PERIOD=100, i_enable=1, ADC model returns 12'hAB3 -> UART model receives 31 30 31 30 31 30 31 31 30 30 31 31 0D 0A; o_busy falls after last send_complete.
2. Hex build, data 12'h0F9 -> bytes 30 46 39 0D 0A.
3. ADC model never asserts dv, ADC_TIMEOUT=50 -> o_adc_err=1 at request+50 cycles, no o_tx_dv; i_clr_status clears it.
4. UART model stalls send_complete beyond SAMPLE_PERIOD -> o_overrun=1, exactly one frame sent, no partial second frame.
5. good_to_reset and send_complete pulsed in the same cycle -> dv low next cycle, next byte loaded, frame intact.
6. i_rst_n asserted mid-frame (byte 5) -> all outputs 0 immediately; after release, no transmission until SAMPLE_PERIOD cycles of enable.

Source files
------------

// File: rtl/adc_uart_sequencer_pkg.sv
// Shared types and constants for the ADC-to-UART sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the sequencer FSM state enum, the ASCII byte constants used when
// rendering a sample as text, and the frame lengths of both output formats.
package adc_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_LOAD      = 3'd3,
    ST_WAIT_ACK  = 3'd4,
    ST_WAIT_DONE = 3'd5
  } state_e;

  localparam logic [7:0] CHAR_ZERO          = 8'h30;
  localparam logic [7:0] CHAR_CR            = 8'h0D;
  localparam logic [7:0] CHAR_LF            = 8'h0A;
  localparam logic [7:0] CHAR_HEX_ALPHA_OFS = 8'h37;

  // 12 binary digits + CR + LF, or 3 hex digits + CR + LF
  localparam int FRAME_LEN_BIN = 14;
  localparam int FRAME_LEN_HEX = 5;

  // Character index must cover the longer of the two frames.
  localparam int CHAR_IDX_W = 4;

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return CHAR_ZERO + {4'd0, n};
    else           return CHAR_HEX_ALPHA_OFS + {4'd0, n};
  endfunction

endpackage

// File: rtl/adc_uart_sequencer_if.sv
// Handshake bundle between the sequencer, the ADC receiver and the UART TX.
// Latency: n/a (wires only).
// Backpressure: n/a; flow control lives in the request/in-process and dv/ack signals.
//
// master: sequencer side (drives ADC request/config and UART byte/valid)
// slave : peripheral side (drives ADC busy/result and UART ack/complete)
interface adc_uart_sequencer_if;
  logic        o_adc_request;
  logic [5:0]  o_adc_cfg;
  logic        i_adc_conv_in_process;
  logic        i_adc_dv;
  logic [11:0] i_adc_data;
  logic [7:0]  o_tx_byte;
  logic        o_tx_dv;
  logic        i_tx_good_to_reset_dv;
  logic        i_tx_send_complete;

  modport master (
    output o_adc_request, o_adc_cfg, o_tx_byte, o_tx_dv,
    input  i_adc_conv_in_process, i_adc_dv, i_adc_data,
           i_tx_good_to_reset_dv, i_tx_send_complete
  );

  modport slave (
    input  o_adc_request, o_adc_cfg, o_tx_byte, o_tx_dv,
    output i_adc_conv_in_process, i_adc_dv, i_adc_data,
           i_tx_good_to_reset_dv, i_tx_send_complete
  );
endinterface

// File: rtl/adc_uart_sequencer_ascii_char_mux.sv
// Renders one ASCII character of a sample frame from the sample and char index.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
//
// Ports: sample_i (captured 12-bit sample), idx_i (char position in frame),
//        byte_o (ASCII byte), last_o (idx_i is the final char of the frame).
// Build option ADC_UART_HEX_FORMAT_EN: defined -> "XYZ\r\n" hex frame,
// undefined -> 12 binary digits MSB first then "\r\n".
module ascii_char_mux
  import adc_uart_pkg::*;
(
  input  logic [11:0]           sample_i,
  input  logic [CHAR_IDX_W-1:0] idx_i,
  output logic [7:0]            byte_o,
  output logic                  last_o
);

  always_comb begin
    byte_o = CHAR_LF;
    last_o = 1'b0;
`ifdef ADC_UART_HEX_FORMAT_EN
    case (idx_i)
      4'd0:    byte_o = hex_char(sample_i[11:8]);
      4'd1:    byte_o = hex_char(sample_i[7:4]);
      4'd2:    byte_o = hex_char(sample_i[3:0]);
      4'd3:    byte_o = CHAR_CR;
      default: byte_o = CHAR_LF;
    endcase
    last_o = (idx_i == CHAR_IDX_W'(FRAME_LEN_HEX - 1));
`else
    // Index 0 is bit 11, so the frame reads MSB first.
    if (idx_i < 4'd12)
      byte_o = CHAR_ZERO + {7'd0, sample_i[4'd11 - idx_i]};
    else if (idx_i == 4'd12)
      byte_o = CHAR_CR;
    else
      byte_o = CHAR_LF;
    last_o = (idx_i == CHAR_IDX_W'(FRAME_LEN_BIN - 1));
`endif
  end

endmodule

// File: rtl/adc_uart_sequencer.sv
// Periodic ADC sampler that streams each 12-bit result to the UART as ASCII text.
// Latency: request 1 cycle after tick; first byte 2 cycles after ADC dv; 1 byte per UART handshake.
// Backpressure: holds each byte until UART ack + send-complete; ticks while busy are dropped and flagged.
//
// Ports: i_clk, i_rst_n (async active-low), i_enable, i_clr_status,
//        bus (master modport: ADC request/cfg/busy/dv/data, UART byte/dv/ack/complete),
//        o_busy (FSM not idle), o_overrun (sticky dropped tick), o_adc_err (sticky ADC timeout).
// Build option ADC_UART_HEX_FORMAT_EN selects the 5-byte hex frame instead of the
// 14-byte binary frame (handled inside ascii_char_mux).
module adc_uart_sequencer
  import adc_uart_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = 50000000,
  parameter int unsigned ADC_TIMEOUT   = 4096,
  parameter logic [5:0]  ADC_CFG       = 6'b100000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_clr_status,
  adc_uart_sequencer_if.master  bus,
  output logic                  o_busy,
  output logic                  o_overrun,
  output logic                  o_adc_err
);

  localparam int TICK_W = $clog2(SAMPLE_PERIOD);
  localparam int TO_W   = $clog2(ADC_TIMEOUT);

  state_e                state_q, state_d;
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [11:0]           sample_q, sample_d;
  logic [CHAR_IDX_W-1:0] idx_q, idx_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic                  tx_dv_q, tx_dv_d;
  logic                  req_q, req_d;
  logic                  busy_q;
  logic                  overrun_q, overrun_d;
  logic                  adc_err_q, adc_err_d;

  logic                  tick;
  logic                  adc_err_set;
  logic                  advance;
  logic [7:0]            char_byte;
  logic                  char_last;

  ascii_char_mux u_char_mux (
    .sample_i (sample_q),
    .idx_i    (idx_q),
    .byte_o   (char_byte),
    .last_o   (char_last)
  );

  // Free-running sample period counter, parked at zero while disabled so the
  // first tick lands a full period after enable rises.
  assign tick = i_enable && (tick_cnt_q == TICK_W'(SAMPLE_PERIOD - 1));

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (!i_enable || tick) tick_cnt_d = '0;
    else                   tick_cnt_d = tick_cnt_q + TICK_W'(1);
  end

  // A byte is finished once the UART reports send-complete after accepting it;
  // ack and complete arriving together in WAIT_ACK count as both.
  assign advance = ((state_q == ST_WAIT_ACK) && bus.i_tx_good_to_reset_dv && bus.i_tx_send_complete) ||
                   ((state_q == ST_WAIT_DONE) && bus.i_tx_send_complete);

  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    sample_d    = sample_q;
    idx_d       = idx_q;
    tx_byte_d   = tx_byte_q;
    tx_dv_d     = tx_dv_q;
    req_d       = req_q;
    adc_err_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d  = ST_REQ;
          req_d    = 1'b1;
          to_cnt_d = '0;
        end
      end

      // The timeout runs from the request, so REQ and WAIT_DATA share it.
      // A result arriving before the busy indication is taken just the same.
      ST_REQ, ST_WAIT_DATA: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (bus.i_adc_dv) begin
          sample_d = bus.i_adc_data;
          idx_d    = '0;
          req_d    = 1'b0;
          state_d  = ST_LOAD;
        end else if (to_cnt_q == TO_W'(ADC_TIMEOUT - 1)) begin
          adc_err_set = 1'b1;
          req_d       = 1'b0;
          state_d     = ST_IDLE;
        end else if ((state_q == ST_REQ) && bus.i_adc_conv_in_process) begin
          req_d   = 1'b0;
          state_d = ST_WAIT_DATA;
        end
      end

      ST_LOAD: begin
        tx_byte_d = char_byte;
        tx_dv_d   = 1'b1;
        state_d   = ST_WAIT_ACK;
      end

      ST_WAIT_ACK: begin
        if (bus.i_tx_good_to_reset_dv) begin
          tx_dv_d = 1'b0;
          state_d = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: ;

      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (char_last) begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end else begin
        idx_d   = idx_q + CHAR_IDX_W'(1);
        state_d = ST_LOAD;
      end
    end
  end

  // Sticky flags: a set event in the same cycle as a clear wins.
  always_comb begin
    overrun_d = overrun_q;
    adc_err_d = adc_err_q;
    if (i_clr_status) begin
      overrun_d = 1'b0;
      adc_err_d = 1'b0;
    end
    if (tick && (state_q != ST_IDLE)) overrun_d = 1'b1;
    if (adc_err_set)                  adc_err_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      to_cnt_q   <= '0;
      sample_q   <= '0;
      idx_q      <= '0;
      tx_byte_q  <= '0;
      tx_dv_q    <= 1'b0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      adc_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      to_cnt_q   <= to_cnt_d;
      sample_q   <= sample_d;
      idx_q      <= idx_d;
      tx_byte_q  <= tx_byte_d;
      tx_dv_q    <= tx_dv_d;
      req_q      <= req_d;
      busy_q     <= (state_d != ST_IDLE);
      overrun_q  <= overrun_d;
      adc_err_q  <= adc_err_d;
    end
  end

  assign bus.o_adc_request = req_q;
  assign bus.o_adc_cfg     = ADC_CFG;
  assign bus.o_tx_byte     = tx_byte_q;
  assign bus.o_tx_dv       = tx_dv_q;
  assign o_busy            = busy_q;
  assign o_overrun         = overrun_q;
  assign o_adc_err         = adc_err_q;

endmodule

// File: tb/tb_adc_uart_sequencer.sv
// Scoreboard bench for adc_uart_sequencer: ADC and UART behavioural models,
// expected frames pushed when the ADC model returns a sample, monitor pops on each byte.
`timescale 1ns/1ps
module tb_adc_uart_sequencer;

  localparam int unsigned SP  = 100;
  localparam int unsigned TO  = 50;
  localparam logic [5:0]  CFG = 6'b100000;
`ifdef ADC_UART_HEX_FORMAT_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 14;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic clr = 1'b0;
  logic busy, overrun, adc_err;

  adc_uart_sequencer_if bus();

  adc_uart_sequencer #(
    .SAMPLE_PERIOD (SP),
    .ADC_TIMEOUT   (TO),
    .ADC_CFG       (CFG)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .i_clr_status (clr),
    .bus          (bus),
    .o_busy       (busy),
    .o_overrun    (overrun),
    .o_adc_err    (adc_err)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         rx_count = 0;
  int         req_count = 0;
  logic [7:0] sb_q[$];
  logic [11:0] adc_val = 12'h000;
  bit         adc_silent = 1'b0;
  bit         adc_fast = 1'b0;
  bit         uart_same = 1'b0;
  int         stall_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Hand-computed frame text for each sample used below.
  task automatic push_expected(input logic [11:0] v);
    string s;
`ifdef ADC_UART_HEX_FORMAT_EN
    case (v)
      12'hAB3: s = "AB3";
      12'h0F9: s = "0F9";
      12'hFFF: s = "FFF";
      12'h5C3: s = "5C3";
      12'h123: s = "123";
      default: s = "???";
    endcase
`else
    case (v)
      12'hAB3: s = "101010110011";
      12'h0F9: s = "000011111001";
      12'hFFF: s = "111111111111";
      12'h5C3: s = "010111000011";
      12'h123: s = "000100100011";
      default: s = "????????????";
    endcase
`endif
    for (int i = 0; i < s.len(); i++) sb_q.push_back(s[i]);
    sb_q.push_back(8'h0D);
    sb_q.push_back(8'h0A);
  endtask

  // which: 0 busy, 1 adc request, 2 overrun, 3 adc_err. cycles = negedges waited.
  task automatic wait_for(input int which, input logic val, input int budget,
                          input string name, output int cycles);
    logic s;
    int   k;
    cycles = budget;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      case (which)
        0:       s = busy;
        1:       s = bus.o_adc_request;
        2:       s = overrun;
        default: s = adc_err;
      endcase
      if (s === val) begin
        cycles = k + 1;
        break;
      end
    end
    check(name, {31'd0, (k < budget)}, 32'd1);
  endtask

  task automatic wait_rx(input int target, input int budget, input string name);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (rx_count >= target) break;
    end
    check(name, {31'd0, (k < budget)}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_request"}, {31'd0, bus.o_adc_request}, 32'd0);
    check({tag, "_cfg"},     {26'd0, bus.o_adc_cfg},     {26'd0, CFG});
    check({tag, "_tx_byte"}, {24'd0, bus.o_tx_byte},     32'd0);
    check({tag, "_tx_dv"},   {31'd0, bus.o_tx_dv},       32'd0);
    check({tag, "_busy"},    {31'd0, busy},              32'd0);
    check({tag, "_overrun"}, {31'd0, overrun},           32'd0);
    check({tag, "_adc_err"}, {31'd0, adc_err},           32'd0);
  endtask

  // ADC receiver model: slow mode shows busy then returns data; fast mode
  // returns data while the request is still high; silent mode never answers.
  initial begin : adc_model
    bus.i_adc_conv_in_process = 1'b0;
    bus.i_adc_dv = 1'b0;
    bus.i_adc_data = 12'h000;
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_adc_request && !adc_silent) begin
        if (!adc_fast) begin
          @(negedge clk);
          @(negedge clk);
          bus.i_adc_conv_in_process = 1'b1;
          repeat (3) @(negedge clk);
        end else begin
          @(negedge clk);
        end
        bus.i_adc_dv = 1'b1;
        bus.i_adc_data = adc_val;
        push_expected(adc_val);
        @(negedge clk);
        bus.i_adc_dv = 1'b0;
        bus.i_adc_conv_in_process = 1'b0;
      end
    end
  end

  // UART transmitter model.
  initial begin : uart_model
    bus.i_tx_good_to_reset_dv = 1'b0;
    bus.i_tx_send_complete = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_tx_dv) begin
        if (uart_same) begin
          bus.i_tx_good_to_reset_dv = 1'b1;
          bus.i_tx_send_complete = 1'b1;
          @(negedge clk);
          bus.i_tx_good_to_reset_dv = 1'b0;
          bus.i_tx_send_complete = 1'b0;
          check("same_cycle_dv_low", {31'd0, bus.o_tx_dv}, 32'd0);
        end else begin
          bus.i_tx_good_to_reset_dv = 1'b1;
          @(negedge clk);
          bus.i_tx_good_to_reset_dv = 1'b0;
          if (stall_cycles > 0) begin
            repeat (stall_cycles) @(negedge clk);
            stall_cycles = 0;
          end
          @(negedge clk);
          bus.i_tx_send_complete = 1'b1;
          @(negedge clk);
          bus.i_tx_send_complete = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor: every new byte presented on the UART is checked.
  initial begin : monitor
    logic prev_dv;
    logic prev_req;
    logic [7:0] exp_b;
    prev_dv = 1'b0;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_adc_request && !prev_req) req_count++;
      if (rst_n && bus.o_tx_dv && !prev_dv) begin
        rx_count++;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_byte_unexpected: got 0x%02h, expected no byte", bus.o_tx_byte);
        end else begin
          exp_b = sb_q.pop_front();
          check("tx_byte", {24'd0, bus.o_tx_byte}, {24'd0, exp_b});
        end
      end
      prev_dv = bus.o_tx_dv;
      prev_req = bus.o_adc_request;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int start;
    int rq;
    int cyc;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // 1: binary/hex frame of 0xAB3, first tick one period after enable
    adc_val = 12'hAB3;
    start = rx_count;
    enable = 1'b1;
    wait_for(1, 1'b1, SP + 10, "t1_request_seen", cyc);
    check("t1_first_tick_cycles", cyc, SP);
    check("t1_busy_in_frame", {31'd0, busy}, 32'd1);
    wait_for(0, 1'b0, 200, "t1_busy_fall", cyc);
    enable = 1'b0;
    check("t1_byte_count", rx_count - start, FRAME_LEN);
    check("t1_sb_empty", sb_q.size(), 0);
    check("t1_no_overrun", {31'd0, overrun}, 32'd0);

    // 2: 0x0F9 with ADC data arriving while request still high
    adc_fast = 1'b1;
    adc_val = 12'h0F9;
    start = rx_count;
    enable = 1'b1;
    wait_for(1, 1'b1, SP + 10, "t2_request_seen", cyc);
    wait_for(0, 1'b0, 200, "t2_busy_fall", cyc);
    enable = 1'b0;
    adc_fast = 1'b0;
    check("t2_byte_count", rx_count - start, FRAME_LEN);
    check("t2_sb_empty", sb_q.size(), 0);

    // 3: ADC timeout
    adc_silent = 1'b1;
    start = rx_count;
    enable = 1'b1;
    wait_for(1, 1'b1, SP + 10, "t3_request_seen", cyc);
    repeat (TO - 1) @(negedge clk);
    check("t3_err_before_timeout", {31'd0, adc_err}, 32'd0);
    check("t3_request_held", {31'd0, bus.o_adc_request}, 32'd1);
    @(negedge clk);
    check("t3_err_at_timeout", {31'd0, adc_err}, 32'd1);
    check("t3_request_dropped", {31'd0, bus.o_adc_request}, 32'd0);
    check("t3_idle_after_timeout", {31'd0, busy}, 32'd0);
    enable = 1'b0;
    check("t3_no_tx", rx_count - start, 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t3_err_cleared", {31'd0, adc_err}, 32'd0);
    adc_silent = 1'b0;

    // 4: UART stall across a tick -> overrun, single frame only
    stall_cycles = 200;
    adc_val = 12'hFFF;
    start = rx_count;
    rq = req_count;
    enable = 1'b1;
    wait_for(2, 1'b1, 400, "t4_overrun_set", cyc);
    enable = 1'b0;
    wait_for(0, 1'b0, 400, "t4_busy_fall", cyc);
    check("t4_byte_count", rx_count - start, FRAME_LEN);
    check("t4_sb_empty", sb_q.size(), 0);
    repeat (250) @(negedge clk);
    check("t4_no_second_frame", rx_count - start, FRAME_LEN);
    check("t4_single_request", req_count - rq, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t4_overrun_cleared", {31'd0, overrun}, 32'd0);

    // 5: ack and send-complete in the same cycle
    uart_same = 1'b1;
    adc_val = 12'h5C3;
    start = rx_count;
    enable = 1'b1;
    wait_for(1, 1'b1, SP + 10, "t5_request_seen", cyc);
    wait_for(0, 1'b0, 200, "t5_busy_fall", cyc);
    enable = 1'b0;
    uart_same = 1'b0;
    check("t5_byte_count", rx_count - start, FRAME_LEN);
    check("t5_sb_empty", sb_q.size(), 0);

    // 6: reset mid-frame, then a full period before the next request
    adc_val = 12'h123;
    start = rx_count;
    enable = 1'b1;
    wait_for(1, 1'b1, SP + 10, "t6_request_seen", cyc);
    wait_rx(start + 5, 200, "t6_byte5_seen");
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_midframe_reset");
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_for(1, 1'b1, SP + 10, "t6_request_after_reset", cyc);
    check("t6_request_delay", cyc, SP);
    start = rx_count;
    wait_for(0, 1'b0, 200, "t6_busy_fall", cyc);
    enable = 1'b0;
    check("t6_byte_count", rx_count - start, FRAME_LEN);

    repeat (5) @(negedge clk);
    check("final_sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
